// File: rtl/bus_ctrl_pkg.sv
// Shared types and helpers for the shared-bus access controller.
package bus_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } bus_state_e;

    // Index width for N requesters, never narrower than one bit.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_bus_ctrl_if.sv
// Request/grant bundle between the requesters and the shared-bus controller.
interface shared_bus_ctrl_if #(
    parameter int unsigned N_REQ = 4
) ();
    localparam int unsigned PTR_W = bus_ctrl_pkg::ptr_w(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [PTR_W-1:0] owner;
    logic             owner_vld;
    logic             bus_turn;
    logic             timeout_evt;

    modport master (
        output req,
        input  gnt, owner, owner_vld, bus_turn, timeout_evt
    );

    modport slave (
        input  req,
        output gnt, owner, owner_vld, bus_turn, timeout_evt
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = bus_ctrl_pkg::ptr_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] win_o,
    output logic [PTR_W-1:0] win_idx_o,
    output logic             any_o
);
    always_comb begin
        int unsigned      idx;
        logic [PTR_W-1:0] sel;
        win_o     = '0;
        win_idx_o = '0;
        any_o     = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (32'(ptr_i) + i) % N_REQ;
            sel = PTR_W'(idx);
            if (!any_o && req_i[sel]) begin
                any_o      = 1'b1;
                win_o[sel] = 1'b1;
                win_idx_o  = sel;
            end
        end
    end
endmodule

// File: rtl/shared_bus_ctrl.sv
// Round-robin owner control for one shared bus: bounded hold, one turnaround cycle between owners.
module shared_bus_ctrl #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    shared_bus_ctrl_if.slave bus
);
    import bus_ctrl_pkg::*;

    localparam int unsigned PTR_W = ptr_w(N_REQ);

    bus_state_e       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic             vld_q, vld_d;
    logic             turn_q, turn_d;
    logic             tevt_q, tevt_d;

    logic [N_REQ-1:0] pick_win;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_any;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i     (bus.req),
        .ptr_i     (ptr_q),
        .win_o     (pick_win),
        .win_idx_o (pick_idx),
        .any_o     (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            owner_q <= '0;
            vld_q   <= 1'b0;
            turn_q  <= 1'b0;
            tevt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            vld_q   <= vld_d;
            turn_q  <= turn_d;
            tevt_q  <= tevt_d;
        end
    end

    always_comb begin
        logic owner_req;
        logic others_req;
        logic do_grant;
        logic do_release;

        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        vld_d      = vld_q;
        turn_d     = 1'b0;
        tevt_d     = 1'b0;
        do_grant   = 1'b0;
        do_release = 1'b0;
        owner_req  = bus.req[owner_q];
        others_req = |(bus.req & ~gnt_q);

        unique case (state_q)
            IDLE:    do_grant = pick_any;
            GRANT: begin
                // A voluntary drop takes precedence, so it never reports as a timeout.
                if (!owner_req) begin
                    do_release = 1'b1;
                end else if ((hold_q == CNT_W'(MAX_HOLD)) && others_req) begin
                    do_release = 1'b1;
                    tevt_d     = 1'b1;
                end else if (hold_q != CNT_W'(MAX_HOLD)) begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                do_grant = pick_any;
                if (!pick_any) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (do_release) begin
            state_d = RELEASE;
            gnt_d   = '0;
            vld_d   = 1'b0;
            turn_d  = 1'b1;
        end

        if (do_grant) begin
            state_d = GRANT;
            gnt_d   = pick_win;
            owner_d = pick_idx;
            vld_d   = 1'b1;
            hold_d  = CNT_W'(1);
            ptr_d   = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.owner       = owner_q;
    assign bus.owner_vld   = vld_q;
    assign bus.bus_turn    = turn_q;
    assign bus.timeout_evt = tevt_q;

endmodule

// File: tb/tb_shared_bus_ctrl.sv
// Scoreboard bench for shared_bus_ctrl: expected grant owners queued with stimulus, popped on each new grant.
module tb_shared_bus_ctrl;
    localparam int unsigned N_REQ    = 4;
    localparam int unsigned MAX_HOLD = 8;
    localparam int unsigned CNT_W    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned tevt_cnt = 0;
    int          exp_q[$];

    shared_bus_ctrl_if #(.N_REQ(N_REQ)) bus_if ();

    shared_bus_ctrl #(
        .N_REQ    (N_REQ),
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"},  32'(bus_if.gnt), 0);
        check({tag, "_vld"},  32'(bus_if.owner_vld), 0);
        check({tag, "_tevt"}, 32'(bus_if.timeout_evt), 0);
    endtask

    // Scoreboard monitor: sampled on the falling edge.
    initial begin : monitor
        logic [N_REQ-1:0] prev;
        int               e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = '0;
            end else begin
                check("onehot", 32'($countones(bus_if.gnt) <= 1), 1);
                check("vld_eq_any", 32'(bus_if.owner_vld), 32'(|bus_if.gnt));
                if (bus_if.timeout_evt) tevt_cnt++;
                if (bus_if.gnt != '0 && bus_if.gnt != prev) begin
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected", 32'(bus_if.gnt), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_gnt", 32'(bus_if.gnt), 32'(1) << e);
                        check("sb_owner", 32'(bus_if.owner), 32'(e));
                    end
                end
                prev = bus_if.gnt;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int i;
        bus_if.req = '0;

        // Reset values
        #2;
        check_idle_outputs("rst");
        check("rst_owner", 32'(bus_if.owner), 0);
        check("rst_turn", 32'(bus_if.bus_turn), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: single request, then pointer sits at 3
        bus_if.req = 4'b0100; exp_q.push_back(2);
        tick();
        check("t1_gnt", 32'(bus_if.gnt), 'h4);
        check("t1_owner", 32'(bus_if.owner), 2);
        check("t1_vld", 32'(bus_if.owner_vld), 1);
        bus_if.req = 4'b1011;
        tick();
        check("t1_turn", 32'(bus_if.bus_turn), 1);
        check("t1_rel_gnt", 32'(bus_if.gnt), 0);
        exp_q.push_back(3);
        tick();
        check("t1_ptr3", 32'(bus_if.gnt), 'h8);
        bus_if.req = '0;
        tick(2);
        check("t1_idle_turn", 32'(bus_if.bus_turn), 0);
        check_idle_outputs("t1_idle");

        // Fresh reset so arbitration starts from requester 0
        @(posedge clk); #3; rst = 1'b1; #1;
        check_idle_outputs("rst2");
        @(posedge clk); #1; rst = 1'b0;

        // 2: all requesting, each owner leaves after two grant cycles
        bus_if.req = 4'b1111; exp_q.push_back(0);
        tick();
        for (int k = 0; k < 5; k++) begin
            i = k % 4;
            check("t2_gnt_c1", 32'(bus_if.gnt), 32'(1) << i);
            tick();
            check("t2_gnt_c2", 32'(bus_if.gnt), 32'(1) << i);
            if (k == 4) bus_if.req = '0;
            else        bus_if.req[i] = 1'b0;
            tick();
            check("t2_turn", 32'(bus_if.bus_turn), 1);
            check("t2_rel_gnt", 32'(bus_if.gnt), 0);
            if (k < 4) begin
                bus_if.req[i] = 1'b1;
                exp_q.push_back((k + 1) % 4);
                tick();
            end
        end
        tick();
        check("t2_idle_turn", 32'(bus_if.bus_turn), 0);

        // 3: forced release after MAX_HOLD when requester 1 waits
        bus_if.req = 4'b0001; exp_q.push_back(0);
        tick(3);
        bus_if.req = 4'b0011;
        for (int c = 3; c < int'(MAX_HOLD); c++) begin
            tick();
            check("t3_hold", 32'(bus_if.gnt), 'h1);
            check("t3_no_tevt", 32'(bus_if.timeout_evt), 0);
        end
        exp_q.push_back(1);
        tick();
        check("t3_rel_gnt", 32'(bus_if.gnt), 0);
        check("t3_tevt", 32'(bus_if.timeout_evt), 1);
        check("t3_turn", 32'(bus_if.bus_turn), 1);
        tick();
        check("t3_gnt1", 32'(bus_if.gnt), 'h2);
        check("t3_tevt_low", 32'(bus_if.timeout_evt), 0);
        bus_if.req = 4'b0001;
        tick();
        exp_q.push_back(0);
        tick();
        check("t3_requeue", 32'(bus_if.gnt), 'h1);
        bus_if.req = '0;
        tick(2);

        // 4: lone owner keeps the bus past MAX_HOLD
        bus_if.req = 4'b0001; exp_q.push_back(0);
        for (int c = 0; c < 20; c++) begin
            tick();
            check("t4_hold", 32'(bus_if.gnt), 'h1);
            check("t4_no_tevt", 32'(bus_if.timeout_evt), 0);
        end
        bus_if.req = '0;
        tick(2);

        // 6: owner 1 drops as requesters 3 and 0 rise, ptr=2
        bus_if.req = 4'b0010; exp_q.push_back(1);
        tick(2);
        bus_if.req = 4'b1001;
        tick();
        check("t6_turn", 32'(bus_if.bus_turn), 1);
        check("t6_rel_gnt", 32'(bus_if.gnt), 0);
        exp_q.push_back(3);
        tick();
        check("t6_gnt3", 32'(bus_if.gnt), 'h8);

        // A request falling during turnaround is not granted
        bus_if.req = 4'b0001;
        tick();
        check("tf_turn", 32'(bus_if.bus_turn), 1);
        bus_if.req = 4'b0010; exp_q.push_back(1);
        tick();
        check("tf_gnt1", 32'(bus_if.gnt), 'h2);
        bus_if.req = '0;
        tick(2);

        // 5: reset between edges during a grant
        bus_if.req = 4'b0010; exp_q.push_back(1);
        tick(2);
        check("t5_pre", 32'(bus_if.gnt), 'h2);
        #2; rst = 1'b1; #1;
        check_idle_outputs("t5_async");
        bus_if.req = 4'b1000;
        @(posedge clk); #1;
        check("t5_in_rst", 32'(bus_if.gnt), 0);
        rst = 1'b0;
        check("t5_no_turn", 32'(bus_if.bus_turn), 0);
        exp_q.push_back(3);
        tick();
        check("t5_gnt3", 32'(bus_if.gnt), 'h8);
        check("t5_owner", 32'(bus_if.owner), 3);
        bus_if.req = '0;
        tick(3);

        check("tevt_count", tevt_cnt, 1);
        check("sb_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
